queue_1_to_2: RTL and testbench

QUEUE_1_TO_2 -- requirements
Module: queue_1_to_2

---
 rtl/queue_pkg.sv | 16 +
 rtl/queue_1_to_2_if.sv | 22 ++
 rtl/queue_ram.sv | 37 +++
 rtl/queue_1_to_2.sv | 80 ++++++++
 tb/tb_queue_1_to_2.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/queue_pkg.sv
// Shared helpers for the queue family: storage depth and pointer wrap.
package queue_pkg;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned inc,
    input int unsigned aw
  );
    return (ptr + inc) & (depth(aw) - 32'd1);
  endfunction

endpackage

// File: rtl/queue_1_to_2_if.sv
// Push/pull bus of the 1-word-in, 2-word-out queue.
// void_o carries the "fewer than two words" flag (void is reserved).
interface queue_1_to_2_if #(
  parameter int Width = 8
) ();
  logic               push;
  logic               pull;
  logic [Width-1:0]   D;
  logic [2*Width-1:0] Q;
  logic               void_o;
  logic               full;

  modport master (
    output push, pull, D,
    input  Q, void_o, full
  );

  modport slave (
    input  push, pull, D,
    output Q, void_o, full
  );
endinterface

// File: rtl/queue_ram.sv
// Queue storage: one write port, two async read ports, async clear.
module queue_ram #(
  parameter int Width        = 8,
  parameter int AddressWidth = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AddressWidth-1:0] waddr,
  input  logic [Width-1:0]        wdata,
  input  logic [AddressWidth-1:0] raddr0,
  output logic [Width-1:0]        rdata0,
  input  logic [AddressWidth-1:0] raddr1,
  output logic [Width-1:0]        rdata1
);
  localparam int Depth = 1 << AddressWidth;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/queue_1_to_2.sv
// Queue taking one word per push and yielding word pairs per pull.
// QUEUE_1_TO_2_LEVEL_EN adds the registered word count as port level.
module queue_1_to_2
  import queue_pkg::*;
#(
  parameter int Width        = 8,
  parameter int AddressWidth = 2
) (
  input  logic               clk,
  input  logic               rst,
  queue_1_to_2_if.slave      bus
`ifdef QUEUE_1_TO_2_LEVEL_EN
  ,
  output logic [AddressWidth:0] level
`endif
);
  localparam int unsigned Depth = depth(AddressWidth);
  localparam int          CntW  = AddressWidth + 1;

  logic [AddressWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddressWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddressWidth-1:0] rd_ptr_nx;
  logic [CntW-1:0]         count_q, count_d;
  logic                    full_w, void_w;
  logic                    push_eff, pull_eff;
  logic [Width-1:0]        lo_word, hi_word;

  // Flags come only from the registered count, never from this cycle's requests
  assign full_w   = (count_q == CntW'(Depth));
  assign void_w   = (count_q < CntW'(2));
  assign push_eff = bus.push & ~full_w;
  assign pull_eff = bus.pull & ~void_w;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_ptr_nx = AddressWidth'(ptr_inc(32'(rd_ptr_q), 1, AddressWidth));
    count_d   = count_q + CntW'(push_eff) - CntW'({pull_eff, 1'b0});
    if (push_eff)
      wr_ptr_d = AddressWidth'(ptr_inc(32'(wr_ptr_q), 1, AddressWidth));
    if (pull_eff)
      rd_ptr_d = AddressWidth'(ptr_inc(32'(rd_ptr_q), 2, AddressWidth));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  queue_ram #(
    .Width        (Width),
    .AddressWidth (AddressWidth)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (push_eff),
    .waddr  (wr_ptr_q),
    .wdata  (bus.D),
    .raddr0 (rd_ptr_q),
    .rdata0 (lo_word),
    .raddr1 (rd_ptr_nx),
    .rdata1 (hi_word)
  );

  assign bus.Q      = {hi_word, lo_word};
  assign bus.void_o = void_w;
  assign bus.full   = full_w;

`ifdef QUEUE_1_TO_2_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: tb/tb_queue_1_to_2.sv
// Directed and randomized checks of queue_1_to_2.
module tb_queue_1_to_2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  logic [7:0] model [$];

`ifdef QUEUE_1_TO_2_LEVEL_EN
  logic [2:0] level;
`endif

  queue_1_to_2_if #(.Width(8)) bus ();

  queue_1_to_2 #(.Width(8), .AddressWidth(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef QUEUE_1_TO_2_LEVEL_EN
    ,
    .level (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic cyc(input logic p, input logic l, input logic [7:0] d);
    bus.push = p;
    bus.pull = l;
    bus.D    = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pull = 1'b0;
  endtask

  task automatic lvl(input string tag, input int exp);
`ifdef QUEUE_1_TO_2_LEVEL_EN
    check(tag, 32'(level), 32'(exp));
`else
    if (exp < 0) $display("bad level %0d", exp);
`endif
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pull = 1'b0;
    bus.D    = 8'h00;
    #12;
    check("rst_void", 32'(bus.void_o), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_q", 32'(bus.Q), 0);
    lvl("rst_level", 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // two pushes form the first pair
    cyc(1, 0, 8'h11);
    check("p1_void", 32'(bus.void_o), 1);
    cyc(1, 0, 8'h22);
    check("p2_void", 32'(bus.void_o), 0);
    check("p2_q", 32'(bus.Q), 32'h2211);
    cyc(0, 1, 8'h00);
    check("pl_void", 32'(bus.void_o), 1);

    // fill, overflow push ignored, drain across wrap
    cyc(1, 0, 8'hA1);
    cyc(1, 0, 8'hA2);
    cyc(1, 0, 8'hA3);
    check("f3_full", 32'(bus.full), 0);
    cyc(1, 0, 8'hA4);
    check("f4_full", 32'(bus.full), 1);
    lvl("f4_level", 4);
    cyc(1, 0, 8'hFF);
    check("ovf_full", 32'(bus.full), 1);
    check("ovf_q", 32'(bus.Q), 32'hA2A1);
    cyc(0, 1, 8'h00);
    check("d1_full", 32'(bus.full), 0);
    check("d1_q", 32'(bus.Q), 32'hA4A3);
    cyc(0, 1, 8'h00);
    check("d2_void", 32'(bus.void_o), 1);
    lvl("d2_level", 0);

    // one word stored, pull held high
    cyc(1, 0, 8'h77);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    check("odd_void", 32'(bus.void_o), 1);
    lvl("odd_level", 1);
    cyc(1, 0, 8'h88);
    check("odd_q", 32'(bus.Q), 32'h8877);
    check("odd_void2", 32'(bus.void_o), 0);

    // count 3, simultaneous push and pull
    cyc(1, 0, 8'h99);
    lvl("c3_level", 3);
    cyc(1, 1, 8'h55);
    check("pp_full", 32'(bus.full), 0);
    check("pp_void", 32'(bus.void_o), 0);
    check("pp_q", 32'(bus.Q), 32'h5599);
    lvl("pp_level", 2);

    // async reset mid-stream with an odd count
    cyc(1, 0, 8'hAA);
    lvl("pr_level", 3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_void", 32'(bus.void_o), 1);
    check("ar_full", 32'(bus.full), 0);
    check("ar_q", 32'(bus.Q), 0);
    lvl("ar_level", 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // randomized traffic against a reference queue
    for (int i = 0; i < 500; i++) begin
      logic p, l;
      logic [7:0] d;
      check("rnd_void", 32'(bus.void_o), 32'(model.size() < 2));
      check("rnd_full", 32'(bus.full), 32'(model.size() == 4));
      p = 1'($urandom_range(0, 1)) & ~bus.full;
      l = 1'($urandom_range(0, 1)) & ~bus.void_o;
      d = 8'($urandom);
      if (l && model.size() >= 2)
        check("rnd_q", 32'(bus.Q), 32'({model[1], model[0]}));
      cyc(p, l, d);
      if (l) begin
        void'(model.pop_front());
        void'(model.pop_front());
      end
      if (p) model.push_back(d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
